output_channel_buffer_bank: RTL

OUTPUT_CHANNEL_BUFFER_BANK -- requirements
Module: output_channel_buffer_bank

---
 rtl/output_channel_buffer_bank.sv | 89 ++++++++
 1 files changed

// File: rtl/output_channel_buffer_bank.sv
// Per-channel circular FIFOs between writeback and the output channels.
// Supports broadcast enqueue, full-channel pass-through and sticky overflow flags.
module output_channel_buffer_bank #(
  parameter int TIA_NUM_OUTPUT_CHANNELS        = 4,
  parameter int TIA_CHANNEL_BUFFER_FIFO_DEPTH  = 4,
  parameter int TIA_CHANNEL_BUFFER_COUNT_WIDTH = 3,
  parameter int TIA_WORD_WIDTH                 = 32,
  parameter int TIA_TAG_WIDTH                  = 2
) (
  input  logic                                                        clock,
  input  logic                                                        reset,
  input  logic [TIA_NUM_OUTPUT_CHANNELS-1:0]                          enqueue_oci,
  input  logic [TIA_WORD_WIDTH-1:0]                                   enqueue_data,
  input  logic [TIA_TAG_WIDTH-1:0]                                    enqueue_tag,
  output logic [TIA_CHANNEL_BUFFER_COUNT_WIDTH*TIA_NUM_OUTPUT_CHANNELS-1:0] output_channel_counts,
  output logic [TIA_NUM_OUTPUT_CHANNELS-1:0]                          output_channel_valid,
  output logic [TIA_WORD_WIDTH*TIA_NUM_OUTPUT_CHANNELS-1:0]           output_channel_data,
  output logic [TIA_TAG_WIDTH*TIA_NUM_OUTPUT_CHANNELS-1:0]            output_channel_tag,
  input  logic [TIA_NUM_OUTPUT_CHANNELS-1:0]                          output_channel_ready,
  output logic [TIA_NUM_OUTPUT_CHANNELS-1:0]                          output_channel_overflow
);

  localparam int N       = TIA_NUM_OUTPUT_CHANNELS;
  localparam int DEPTH   = TIA_CHANNEL_BUFFER_FIFO_DEPTH;
  localparam int CW      = TIA_CHANNEL_BUFFER_COUNT_WIDTH;
  localparam int W       = TIA_WORD_WIDTH;
  localparam int T       = TIA_TAG_WIDTH;
  localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int ENTRY_W = T + W;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [PTR_W-1:0]   head_q  [N];
  logic [PTR_W-1:0]   tail_q  [N];
  logic [CW-1:0]      count_q [N];
  logic [ENTRY_W-1:0] mem_q   [N][DEPTH];
  logic [N-1:0]       overflow_q;

  logic [N-1:0] deq;
  logic [N-1:0] enq;
  logic [N-1:0] drop;

  always_comb begin
    deq                   = '0;
    enq                   = '0;
    drop                  = '0;
    output_channel_counts = '0;
    output_channel_valid  = '0;
    output_channel_data   = '0;
    output_channel_tag    = '0;
    for (int unsigned i = 0; i < N; i++) begin
      output_channel_valid[i] = (count_q[i] != '0);
      deq[i]  = (count_q[i] != '0) & output_channel_ready[i];
      // A full channel still accepts when its head leaves on the same edge.
      enq[i]  = enqueue_oci[i] & ((count_q[i] != FULL_COUNT) | deq[i]);
      drop[i] = enqueue_oci[i] & (count_q[i] == FULL_COUNT) & ~deq[i];
      output_channel_counts[i*CW +: CW] = count_q[i];
      {output_channel_tag[i*T +: T], output_channel_data[i*W +: W]} = mem_q[i][head_q[i]];
    end
  end

  assign output_channel_overflow = overflow_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < N; i++) begin
        head_q[i]  <= '0;
        tail_q[i]  <= '0;
        count_q[i] <= '0;
      end
      overflow_q <= '0;
    end else begin
      for (int unsigned i = 0; i < N; i++) begin
        if (enq[i]) tail_q[i] <= tail_q[i] + PTR_W'(1);
        if (deq[i]) head_q[i] <= head_q[i] + PTR_W'(1);
        if (enq[i] && !deq[i])      count_q[i] <= count_q[i] + CW'(1);
        else if (deq[i] && !enq[i]) count_q[i] <= count_q[i] - CW'(1);
        if (drop[i]) overflow_q[i] <= 1'b1;
      end
    end
  end

  // Storage is not reset; writes are gated so nothing lands while reset is held.
  always_ff @(posedge clock) begin
    for (int unsigned i = 0; i < N; i++) begin
      if (reset && enq[i]) mem_q[i][tail_q[i]] <= {enqueue_tag, enqueue_data};
    end
  end

endmodule
